mem_bist_ctrl: RTL and testbench
================================

Name: mem_bist_ctrl

Overview:
Built-in self-test sequencer and access arbiter for the 32x8 synchronous memory (read/write strobes, addr, data_in, data_out registered one cycle after a read).
- On a start pulse it takes ownership of the memory and runs two march phases: clear/verify-zero, then write/verify data=address. It counts mismatches and records the first failure.
- When idle or done, it forwards a host port straight to the memory.

Parameters:
ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W
DATA_W, 8, memory data width
ERR_W, 8, error counter width (saturating)

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin BIST; honoured only in IDLE or DONE
host_read  in  1  host read strobe
host_write  in  1  host write strobe
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  equals mem_data_out
host_gnt  out  1  1 when host owns the memory (IDLE or DONE)
mem_read  out  1  to memory read
mem_write  out  1  to memory write
mem_addr  out  ADDR_W  to memory addr
mem_data_in  out  DATA_W  to memory data_in
mem_data_out  in  DATA_W  from memory, valid one cycle after mem_read
busy  out  1  BIST running
done  out  1  level, high in DONE until next start or reset
pass  out  1  done && err_count==0
err_count  out  ERR_W  mismatches this run, saturates at all-ones
fail_valid  out  1  first mismatch captured
fail_addr  out  ADDR_W  address of first mismatch
fail_data  out  DATA_W  data read at first mismatch

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; busy=0, done=0, fail_valid=0, err_count=0, fail_addr=0, fail_data=0, addr counter=0, compare pipeline cleared. host_gnt=1 after reset. A reset mid-run aborts immediately. No further BIST strobes are issued. Memory contents are left as they are.
- States: IDLE, WR0, RD0, DRN0, WRA, RDA, DRNA, DONE.
- IDLE/DONE + start -> WR0, addr=0. Clears err_count, fail_* and done on the same edge.
- WR0: mem_write=1, mem_data_in=0, mem_addr=addr, addr++ each cycle. After DEPTH-1 -> RD0, addr wraps to 0.
- RD0: mem_read=1 every cycle, addr++. Expected value 0 is registered alongside the address. After the last address -> DRN0.
- DRN0: no strobes; compares the last read -> WRA.
- WRA: as WR0 but mem_data_in = addr zero-extended or truncated to DATA_W -> RDA.
- RDA: as RD0, expected value = addr -> DRNA -> DONE.
- Compare: in the cycle after each BIST read, mem_data_out is checked against the registered expected value.
  - On mismatch, err_count increments (saturating).
  - On the first mismatch, fail_addr/fail_data load and fail_valid=1.
  - The compare in the DRN cycle is counted before the transition.
- busy=1 in all states except IDLE and DONE. A full run is 4*DEPTH+2 = 130 busy cycles.
- start while busy is ignored.
- Ownership: host_gnt=1 forwards host_* to mem_* combinationally. While busy, host strobes are dropped and mem_* reflect BIST only.
- mem_read and mem_write are never both 1 from the BIST side.

Decomposition:
- mem_bist_pkg: state enum bist_state_e, default widths, DEPTH, phase-pattern constants (PAT_ZERO, PAT_ADDR).
- Sub-module mem_bist_chk: registered expected/addr pipeline, comparator, saturating counter, first-fail capture. Its inputs are the compare-enable, expected value and address.

Test Plan:
1. rst=1 for 2 cycles -> busy=0, done=0, err_count=0, fail_valid=0, host_gnt=1, mem_read=0, mem_write=0.
2. Good memory, start pulse -> busy high exactly 130 cycles, then done=1, pass=1, err_count=0. Afterwards a host read of addr 17 returns 8'h11.
3. Memory with addr 5 bit0 stuck-at-1 -> err_count=1, fail_addr=5, fail_data=8'h01, fail_valid=1, pass=0.
4. Memory with data_out bit0 stuck-at-0 at all addresses -> zero-phase clean. err_count=16, fail_addr=1, fail_data=8'h00.
5. rst pulsed 40 cycles into the run (during RD0) -> next cycle IDLE, busy=0, strobes low. A new start completes in 130 cycles with pass=1.
6. IDLE: host_write addr 3 data 8'hA5, then host_read addr 3 -> host_rdata=8'hA5 next cycle. A host_write during busy is not forwarded and leaves mem_write under BIST control.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST sequencer.
// States, default widths and march data patterns.
package mem_bist_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ERR_W  = 8;
   localparam int DEPTH      = 2 ** DEF_ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      WR0,
      RD0,
      DRN0,
      WRA,
      RDA,
      DRNA,
      DONE
   } bist_state_e;

   typedef enum logic {
      PAT_ZERO,
      PAT_ADDR
   } pat_e;

endpackage

// File: rtl/mem_bist_chk.sv
// Read-data checker: delays expected value/address one cycle,
// compares against memory output, counts errors, captures first fail.
module mem_bist_chk
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ERR_W  = DEF_ERR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              cmp_en,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rdata,
   output logic [ERR_W-1:0]  err_count,
   output logic              fail_valid,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   logic              v_q;
   logic [DATA_W-1:0] exp_q;
   logic [ADDR_W-1:0] addr_q;
   logic              miss;

   assign miss = v_q && (rdata != exp_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q        <= 1'b0;
         exp_q      <= '0;
         addr_q     <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_addr  <= '0;
         fail_data  <= '0;
      end else begin
         v_q    <= cmp_en;
         exp_q  <= exp_data;
         addr_q <= addr;
         if (clr) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
         end else if (miss) begin
            if (err_count != '1)
               err_count <= err_count + 1'b1;
            if (!fail_valid) begin
               fail_valid <= 1'b1;
               fail_addr  <= addr_q;
               fail_data  <= rdata;
            end
         end
      end
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST sequencer and host/BIST arbiter for a small synchronous RAM.
// Runs zero then data=address march phases; host owns RAM otherwise.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ERR_W  = DEF_ERR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              host_read,
   input  logic              host_write,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_gnt,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic              fail_valid,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   bist_state_e       state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [DATA_W-1:0] addr_data;
   logic [DATA_W-1:0] pat_data;
   pat_e              pat;
   logic              last;
   logic              b_read;
   logic              b_write;
   logic              cmp_en;
   logic              clr;

   assign addr_data = DATA_W'(addr);
   assign pat_data  = (pat == PAT_ADDR) ? addr_data : '0;
   assign last      = &addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr  <= '0;
      end else begin
         state <= state_n;
         addr  <= addr_n;
      end
   end

   always_comb begin
      state_n = state;
      addr_n  = addr;
      b_read  = 1'b0;
      b_write = 1'b0;
      cmp_en  = 1'b0;
      clr     = 1'b0;
      pat     = PAT_ZERO;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = WR0;
               addr_n  = '0;
               clr     = 1'b1;
            end
         end
         WR0: begin
            b_write = 1'b1;
            addr_n  = addr + 1'b1;
            if (last) state_n = RD0;
         end
         RD0: begin
            b_read = 1'b1;
            cmp_en = 1'b1;
            addr_n = addr + 1'b1;
            if (last) state_n = DRN0;
         end
         DRN0: state_n = WRA;
         WRA: begin
            pat     = PAT_ADDR;
            b_write = 1'b1;
            addr_n  = addr + 1'b1;
            if (last) state_n = RDA;
         end
         RDA: begin
            pat    = PAT_ADDR;
            b_read = 1'b1;
            cmp_en = 1'b1;
            addr_n = addr + 1'b1;
            if (last) state_n = DRNA;
         end
         DRNA: state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   assign busy       = (state != IDLE) && (state != DONE);
   assign done       = (state == DONE);
   assign host_gnt   = !busy;
   assign pass       = done && (err_count == '0);
   assign host_rdata = mem_data_out;

   // Host path is purely combinational so host timing matches a bare RAM
   always_comb begin
      if (host_gnt) begin
         mem_read    = host_read;
         mem_write   = host_write;
         mem_addr    = host_addr;
         mem_data_in = host_wdata;
      end else begin
         mem_read    = b_read;
         mem_write   = b_write;
         mem_addr    = addr;
         mem_data_in = pat_data;
      end
   end

   mem_bist_chk #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .ERR_W (ERR_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .cmp_en    (cmp_en),
      .exp_data  (pat_data),
      .addr      (addr),
      .rdata     (mem_data_out),
      .err_count (err_count),
      .fail_valid(fail_valid),
      .fail_addr (fail_addr),
      .fail_data (fail_data)
   );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 32x8 RAM model
// that can inject read-side stuck-at faults.
module tb_mem_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       host_read;
   logic       host_write;
   logic [4:0] host_addr;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       host_gnt;
   logic       mem_read;
   logic       mem_write;
   logic [4:0] mem_addr;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic       fail_valid;
   logic [4:0] fail_addr;
   logic [7:0] fail_data;

   int total = 0;
   int bad   = 0;
   int fault = 0;

   logic [7:0] mem [32];

   always #5 clk = ~clk;

   mem_bist_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .host_read   (host_read),
      .host_write  (host_write),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .host_gnt    (host_gnt),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_data_in (mem_data_in),
      .mem_data_out(mem_data_out),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_count   (err_count),
      .fail_valid  (fail_valid),
      .fail_addr   (fail_addr),
      .fail_data   (fail_data)
   );

   // fault 1: addr 5 bit0 stuck-at-1; fault 2: bit0 stuck-at-0 everywhere
   always @(posedge clk) begin
      logic [7:0] d;
      if (mem_write) mem[mem_addr] <= mem_data_in;
      if (mem_read) begin
         d = mem[mem_addr];
         if (fault == 1 && mem_addr == 5'd5) d[0] = 1'b1;
         if (fault == 2) d[0] = 1'b0;
         mem_data_out <= d;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_bist(input int poke, output int n);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         if (n == poke) start = 1'b1;
         tick();
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || err_count !== 8'd0) begin
         $display("FAIL reset_status busy=%b done=%b err=%0d want 0 0 0",
                  busy, done, err_count);
         bad++;
      end
      total++;
      if (fail_valid !== 1'b0 || host_gnt !== 1'b1) begin
         $display("FAIL reset_own fail_valid=%b host_gnt=%b want 0 1",
                  fail_valid, host_gnt);
         bad++;
      end
      total++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         $display("FAIL reset_strobes rd=%b wr=%b want 0 0",
                  mem_read, mem_write);
         bad++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_good();
      int n;
      fault = 0;
      run_bist(50, n);
      total++;
      if (n != 130) begin
         $display("FAIL good_busy_cycles got=%0d want=130", n);
         bad++;
      end
      total++;
      if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0) begin
         $display("FAIL good_result done=%b pass=%b err=%0d want 1 1 0",
                  done, pass, err_count);
         bad++;
      end
      host_read = 1'b1;
      host_addr = 5'd17;
      tick();
      host_read = 1'b0;
      total++;
      if (host_rdata !== 8'h11) begin
         $display("FAIL good_host_read got=%h want=11", host_rdata);
         bad++;
      end
   endtask

   task automatic test_stuck1();
      int n;
      fault = 1;
      run_bist(0, n);
      total++;
      if (err_count !== 8'd1 || fail_valid !== 1'b1 || pass !== 1'b0) begin
         $display("FAIL stuck1_status err=%0d fv=%b pass=%b want 1 1 0",
                  err_count, fail_valid, pass);
         bad++;
      end
      total++;
      if (fail_addr !== 5'd5 || fail_data !== 8'h01) begin
         $display("FAIL stuck1_capture addr=%0d data=%h want 5 01",
                  fail_addr, fail_data);
         bad++;
      end
      fault = 0;
   endtask

   task automatic test_stuck0();
      int n;
      fault = 2;
      run_bist(0, n);
      total++;
      if (err_count !== 8'd16 || done !== 1'b1 || pass !== 1'b0) begin
         $display("FAIL stuck0_status err=%0d done=%b pass=%b want 16 1 0",
                  err_count, done, pass);
         bad++;
      end
      total++;
      if (fail_addr !== 5'd1 || fail_data !== 8'h00 || fail_valid !== 1'b1) begin
         $display("FAIL stuck0_capture addr=%0d data=%h fv=%b want 1 00 1",
                  fail_addr, fail_data, fail_valid);
         bad++;
      end
      fault = 0;
   endtask

   task automatic test_reset_mid();
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      total++;
      if (busy !== 1'b1 || mem_read !== 1'b1) begin
         $display("FAIL mid_in_rd0 busy=%b rd=%b want 1 1", busy, mem_read);
         bad++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
          host_gnt !== 1'b1 || err_count !== 8'd0 || fail_valid !== 1'b0) begin
         $display("FAIL mid_abort busy=%b rd=%b wr=%b gnt=%b err=%0d fv=%b want 0 0 0 1 0 0",
                  busy, mem_read, mem_write, host_gnt, err_count, fail_valid);
         bad++;
      end
      run_bist(0, n);
      total++;
      if (n != 130 || pass !== 1'b1) begin
         $display("FAIL mid_rerun cycles=%0d pass=%b want 130 1", n, pass);
         bad++;
      end
   endtask

   task automatic test_host();
      int n;
      host_write = 1'b1;
      host_addr  = 5'd3;
      host_wdata = 8'hA5;
      #1;
      total++;
      if (mem_write !== 1'b1 || mem_addr !== 5'd3 || mem_data_in !== 8'hA5) begin
         $display("FAIL host_fwd wr=%b addr=%0d data=%h want 1 3 a5",
                  mem_write, mem_addr, mem_data_in);
         bad++;
      end
      tick();
      host_write = 1'b0;
      host_read  = 1'b1;
      tick();
      host_read = 1'b0;
      total++;
      if (host_rdata !== 8'hA5) begin
         $display("FAIL host_rw got=%h want=a5", host_rdata);
         bad++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 34; i++) tick();
      host_write = 1'b1;
      host_wdata = 8'h5A;
      #1;
      total++;
      if (mem_write !== 1'b0 || mem_read !== 1'b1 || host_gnt !== 1'b0) begin
         $display("FAIL host_blocked wr=%b rd=%b gnt=%b want 0 1 0",
                  mem_write, mem_read, host_gnt);
         bad++;
      end
      tick();
      host_write = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         tick();
      end
      total++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         $display("FAIL host_run_end done=%b pass=%b want 1 1", done, pass);
         bad++;
      end
      host_read = 1'b1;
      host_addr = 5'd3;
      tick();
      host_read = 1'b0;
      total++;
      if (host_rdata !== 8'h03) begin
         $display("FAIL host_after_bist got=%h want=03", host_rdata);
         bad++;
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      host_read  = 1'b0;
      host_write = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
      test_reset();
      test_good();
      test_stuck1();
      test_stuck0();
      test_reset_mid();
      test_host();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
